// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment readback path: digit patterns, special codes, FSM states.
// Optional feature macro used by this slice: SEG7DEC_DP_EN (decimal-point capture).
package seg7_pkg;

    localparam int unsigned SEG_W  = 7;
    localparam int unsigned CODE_W = 4;

    // Segment order is {a,b,c,d,e,f,g}, 1 = lit; entry d is the pattern for digit d.
    localparam logic [9:0][SEG_W-1:0] SEG_DIGITS = {
        7'b1111011,  // 9
        7'b1111111,  // 8
        7'b1110000,  // 7
        7'b1011111,  // 6
        7'b1011011,  // 5
        7'b0110011,  // 4
        7'b1111001,  // 3
        7'b1101101,  // 2
        7'b0110000,  // 1
        7'b1111110   // 0
    };

    localparam logic [SEG_W-1:0]  SEG_BLANK  = 7'b0000000;
    localparam logic [CODE_W-1:0] CODE_BLANK = 4'hA;
    localparam logic [CODE_W-1:0] CODE_INV   = 4'hF;

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/seg7dec_scan_if.sv
// Display bus seen by the scan decoder plus the decoded frame it returns.
// SEG7DEC_DP_EN adds the decimal-point input and per-digit decimal-point output.
interface seg7dec_scan_if #(
    parameter int unsigned NDIG = 4
);
    logic [6:0]        seg;
    logic [NDIG-1:0]   an;
    logic [4*NDIG-1:0] dec_o;
    logic              valid;
    logic              err;
`ifdef SEG7DEC_DP_EN
    logic              dp;
    logic [NDIG-1:0]   dp_o;

    modport master (output seg, an, dp, input dec_o, valid, err, dp_o);
    modport slave  (input seg, an, dp, output dec_o, valid, err, dp_o);
`else
    modport master (output seg, an, input dec_o, valid, err);
    modport slave  (input seg, an, output dec_o, valid, err);
`endif
endinterface

// File: rtl/seg7_lut.sv
// Combinational 7-segment pattern to digit code lookup with invalid flag.
// Independent of SEG7DEC_DP_EN (decimal point is handled by the caller).
module seg7_lut
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0]  seg,
    output logic [CODE_W-1:0] code_c,
    output logic              inv_c
);

    // Default to invalid, then override on a digit or blank match.
    always_comb begin
        code_c = CODE_INV;
        inv_c  = 1'b1;
        for (int unsigned d = 0; d < 10; d++) begin
            if (seg == SEG_DIGITS[4'(d)]) begin
                code_c = CODE_W'(d);
                inv_c  = 1'b0;
            end
        end
        if (seg == SEG_BLANK) begin
            code_c = CODE_BLANK;
            inv_c  = 1'b0;
        end
    end

endmodule

// File: rtl/seg7dec_scan.sv
// Multiplexed 7-segment bus readback: qualifies each digit for stability,
// decodes it and publishes a complete NDIG-digit frame.
// SEG7DEC_DP_EN: also samples dp with the pattern and returns it per digit on dp_o.
module seg7dec_scan
    import seg7_pkg::*;
#(
    parameter int unsigned NDIG   = 4,
    parameter int unsigned STABLE = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    seg7dec_scan_if.slave bus
);

    localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int unsigned CNT_W = 4;
`ifdef SEG7DEC_DP_EN
    localparam int unsigned SMP_W = NDIG + SEG_W + 1;
`else
    localparam int unsigned SMP_W = NDIG + SEG_W;
`endif

    logic [SMP_W-1:0]             cur, prev;
    logic [CNT_W-1:0]             cnt, cnt_nxt;
    state_t                       state;
    logic [IDX_W-1:0]             idx;
    logic                         match, onehot, cap, frame;
    logic [CODE_W-1:0]            lut_code;
    logic                         lut_inv;
    logic [NDIG-1:0][CODE_W-1:0]  slot_code, code_nxt;
    logic [NDIG-1:0]              slot_inv, inv_nxt, captured;
    logic [NDIG-1:0][CODE_W-1:0]  dec_r;
    logic                         valid_r, err_r;

`ifdef SEG7DEC_DP_EN
    logic [NDIG-1:0] slot_dp, dp_nxt, dp_r;
    assign cur = {bus.dp, bus.an, bus.seg};
`else
    assign cur = {bus.an, bus.seg};
`endif

    seg7_lut u_lut (
        .seg    (bus.seg),
        .code_c (lut_code),
        .inv_c  (lut_inv)
    );

    // Stability qualification, one-hot check, slot index and next slot contents.
    always_comb begin
        match   = (cur == prev);
        cnt_nxt = '0;
        if (match) begin
            cnt_nxt = (cnt == CNT_W'(STABLE - 1)) ? cnt : cnt + CNT_W'(1);
        end
        onehot = (bus.an != '0) && ((bus.an & (bus.an - NDIG'(1))) == '0);
        idx    = '0;
        for (int unsigned k = 0; k < NDIG; k++) begin
            if (bus.an[IDX_W'(k)]) idx = IDX_W'(k);
        end
        cap      = (state == ST_WAIT) && onehot && (cnt_nxt == CNT_W'(STABLE - 1));
        frame    = cap && ((captured | bus.an) == '1);
        code_nxt = slot_code;
        inv_nxt  = slot_inv;
        if (cap) begin
            code_nxt[idx] = lut_code;
            inv_nxt[idx]  = lut_inv;
        end
`ifdef SEG7DEC_DP_EN
        dp_nxt = slot_dp;
        if (cap) dp_nxt[idx] = bus.dp;
`endif
    end

    // Sample register and saturating stability counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= '0;
            cnt  <= '0;
        end else begin
            prev <= cur;
            cnt  <= cnt_nxt;
        end
    end

    // Capture FSM: one capture per stable run, re-armed by any bus change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_WAIT;
        end else begin
            case (state)
                ST_WAIT: if (cap)    state <= ST_HOLD;
                ST_HOLD: if (!match) state <= ST_WAIT;
            endcase
        end
    end

    // Slot storage; captured bits and invalid flags clear when a frame is published.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_code <= '0;
            slot_inv  <= '0;
            captured  <= '0;
`ifdef SEG7DEC_DP_EN
            slot_dp   <= '0;
`endif
        end else begin
            slot_code <= code_nxt;
            slot_inv  <= frame ? '0 : inv_nxt;
            if (frame)    captured <= '0;
            else if (cap) captured <= captured | bus.an;
`ifdef SEG7DEC_DP_EN
            slot_dp   <= dp_nxt;
`endif
        end
    end

    // Frame outputs, updated together with a one-cycle valid pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_r   <= '0;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
`ifdef SEG7DEC_DP_EN
            dp_r    <= '0;
`endif
        end else begin
            valid_r <= frame;
            if (frame) begin
                dec_r <= code_nxt;
                err_r <= |inv_nxt;
`ifdef SEG7DEC_DP_EN
                dp_r  <= dp_nxt;
`endif
            end
        end
    end

    assign bus.dec_o = dec_r;
    assign bus.valid = valid_r;
    assign bus.err   = err_r;
`ifdef SEG7DEC_DP_EN
    assign bus.dp_o  = dp_r;
`endif

endmodule

// File: tb/tb_seg7dec_scan.sv
// Self-checking bench for seg7dec_scan (NDIG=4, STABLE=3), default build (SEG7DEC_DP_EN undefined
// is assumed by the reference model; dp is tied low if the macro is defined).
module tb_seg7dec_scan;

    localparam int unsigned NDIG   = 4;
    localparam int unsigned STABLE = 3;

    localparam logic [6:0] PAT [10] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };
    localparam logic [6:0] BLK = 7'b0000000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg7dec_scan_if #(.NDIG(NDIG)) bus ();

    seg7dec_scan #(.NDIG(NDIG), .STABLE(STABLE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

`ifdef SEG7DEC_DP_EN
    initial bus.dp = 1'b0;
`endif

    int n_cmp  = 0;
    int n_bad  = 0;
    int pulses = 0;
    int cyc    = 0;
    int last_v = -100;

    // Reference model state: run length of identical samples, per-slot codes.
    logic [10:0] m_prev;
    int          m_run;
    logic [3:0]  m_slot [NDIG];
    logic [3:0]  m_got;
    logic [15:0] m_dec;
    logic        m_err;
    logic        m_valid;

    function automatic logic [3:0] ref_decode(input logic [6:0] s);
        for (int d = 0; d < 10; d++) if (s == PAT[d]) return 4'(d);
        if (s == BLK) return 4'hA;
        return 4'hF;
    endfunction

    task automatic model_reset();
        m_prev  = '0;
        m_run   = 1;
        m_got   = '0;
        m_dec   = '0;
        m_err   = 1'b0;
        m_valid = 1'b0;
        for (int k = 0; k < NDIG; k++) m_slot[k] = '0;
    endtask

    task automatic model_tick(input logic [6:0] s, input logic [3:0] a);
        logic [10:0] cur;
        cur = {a, s};
        if (cur == m_prev) begin
            if (m_run < 1000) m_run++;
        end else begin
            m_prev = cur;
            m_run  = 1;
        end
        m_valid = 1'b0;
        if (m_run == STABLE && $onehot(a)) begin
            for (int k = 0; k < NDIG; k++) begin
                if (a[k]) begin
                    m_slot[k] = ref_decode(s);
                    m_got[k]  = 1'b1;
                end
            end
            if (&m_got) begin
                m_err = 1'b0;
                for (int k = 0; k < NDIG; k++) begin
                    m_dec[4*k +: 4] = m_slot[k];
                    if (m_slot[k] == 4'hF) m_err = 1'b1;
                end
                m_valid = 1'b1;
                m_got   = '0;
            end
        end
    endtask

    task automatic check_cycle();
        n_cmp++;
        if (bus.valid !== m_valid || bus.err !== m_err || bus.dec_o !== m_dec) begin
            n_bad++;
            $display("FAIL cycle%0d: valid=%b err=%b dec_o=%h, required valid=%b err=%b dec_o=%h",
                     cyc, bus.valid, bus.err, bus.dec_o, m_valid, m_err, m_dec);
        end
        if (bus.valid === 1'b1) begin
            pulses++;
            n_cmp++;
            if (cyc - last_v < int'(STABLE)) begin
                n_bad++;
                $display("FAIL spacing: valid %0d cycles after previous, required >= %0d",
                         cyc - last_v, STABLE);
            end
            last_v = cyc;
        end
    endtask

    // Drive one cycle of bus values (at negedge), advance the model, check outputs.
    task automatic step(input logic [6:0] s, input logic [3:0] a);
        bus.seg = s;
        bus.an  = a;
        @(posedge clk);
        model_tick(s, a);
        cyc++;
        @(negedge clk);
        check_cycle();
    endtask

    task automatic hold(input logic [6:0] s, input logic [3:0] a, input int n);
        for (int i = 0; i < n; i++) step(s, a);
    endtask

    task automatic check_frame(input string name, input int p0, input int want_p,
                               input logic [15:0] want_dec, input logic want_err);
        n_cmp++;
        if (pulses - p0 != want_p || bus.dec_o !== want_dec || bus.err !== want_err) begin
            n_bad++;
            $display("FAIL %s: pulses=%0d dec_o=%h err=%b, required pulses=%0d dec_o=%h err=%b",
                     name, pulses - p0, bus.dec_o, bus.err, want_p, want_dec, want_err);
        end
    endtask

    task automatic check_reset(input string name);
        n_cmp++;
        if (bus.dec_o !== '0 || bus.valid !== 1'b0 || bus.err !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: dec_o=%h valid=%b err=%b, required all zero",
                     name, bus.dec_o, bus.valid, bus.err);
        end
    endtask

    typedef struct {
        logic [3:0][6:0] p;
        logic [15:0]     dec;
        logic            err;
    } frame_vec_t;

    frame_vec_t vecs [5];

    initial begin
        int p0;
        logic [3:0] a;
        logic [6:0] s;
        int r;

        vecs[0] = '{p: {7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000}, dec: 16'h4321, err: 1'b0};
        vecs[1] = '{p: {7'b1110000, 7'b1011111, 7'b1011011, 7'b1010101}, dec: 16'h765F, err: 1'b1};
        vecs[2] = '{p: {7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000}, dec: 16'hAAAA, err: 1'b0};
        vecs[3] = '{p: {7'b0000000, 7'b1111110, 7'b1111011, 7'b1111111}, dec: 16'hA098, err: 1'b0};
        vecs[4] = '{p: {7'b0000001, 7'b1110000, 7'b1011111, 7'b1011011}, dec: 16'hF765, err: 1'b1};

        bus.seg = '0;
        bus.an  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset("reset_state");
        rst_n = 1'b1;

        // Table-driven full frames, 5 cycles per digit.
        foreach (vecs[i]) begin
            p0 = pulses;
            for (int k = 0; k < NDIG; k++) hold(vecs[i].p[k], 4'(1 << k), 5);
            check_frame($sformatf("frame_vec%0d", i), p0, 1, vecs[i].dec, vecs[i].err);
        end

        // Slot 1 held only two cycles: not captured until it is held long enough.
        p0 = pulses;
        hold(PAT[1], 4'b0001, 5);
        hold(PAT[2], 4'b0010, 2);
        hold(PAT[3], 4'b0100, 5);
        hold(PAT[4], 4'b1000, 5);
        check_frame("short_hold_nocap", p0, 0, 16'hF765, 1'b1);
        hold(PAT[2], 4'b0010, 5);
        check_frame("short_hold_late", p0, 1, 16'h4321, 1'b0);

        // Multi-hot enable never captures.
        p0 = pulses;
        hold(PAT[8], 4'b0011, 10);
        check_frame("multi_hot", p0, 0, 16'h4321, 1'b0);
        hold(PAT[8], 4'b0000, 4);
        check_frame("zero_an", p0, 0, 16'h4321, 1'b0);

        // Blank frame with one digit held 20 cycles: single capture, single frame.
        p0 = pulses;
        hold(BLK, 4'b0001, 5);
        hold(BLK, 4'b0010, 5);
        hold(BLK, 4'b0100, 20);
        hold(BLK, 4'b1000, 5);
        check_frame("blank_long_hold", p0, 1, 16'hAAAA, 1'b0);

        // Reset after three captured slots; restart from slot 3 so stale bits would show.
        p0 = pulses;
        hold(PAT[7], 4'b0001, 5);
        hold(PAT[7], 4'b0010, 5);
        hold(PAT[7], 4'b0100, 5);
        rst_n = 1'b0;
        #1;
        check_reset("mid_frame_reset");
        bus.seg = '0;
        bus.an  = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        p0 = pulses;
        hold(PAT[4], 4'b1000, 5);
        check_frame("post_reset_partial", p0, 0, 16'h0000, 1'b0);
        hold(PAT[1], 4'b0001, 5);
        hold(PAT[2], 4'b0010, 5);
        hold(PAT[3], 4'b0100, 5);
        check_frame("post_reset_frame", p0, 1, 16'h4321, 1'b0);

        // Randomised bus activity against the reference model.
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7)       a = 4'(1 << $urandom_range(0, 3));
            else if (r == 7) a = 4'b0000;
            else             a = 4'($urandom_range(0, 15));
            r = int'($urandom_range(0, 13));
            if (r < 10)       s = PAT[r];
            else if (r == 10) s = BLK;
            else              s = 7'($urandom_range(0, 127));
            hold(s, a, int'($urandom_range(1, 6)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
